// File: rtl/snake_engine_if.sv
// Bus between snake_engine and its clients: direction input, food randomiser, renderer read port, display outputs.
interface snake_engine_if #(
    parameter int unsigned GRID_W  = 40,
    parameter int unsigned GRID_H  = 30,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned SCORE_W = 16
);
    localparam int unsigned HW = $clog2(GRID_W);
    localparam int unsigned VW = $clog2(GRID_H);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    logic               Tick;
    logic               Start;
    logic               Pause;
    logic               DirValid;
    logic [1:0]         Dir;
    logic               FoodReq;
    logic               FoodValid;
    logic [VW-1:0]      FoodV;
    logic [HW-1:0]      FoodH;
    logic [VW-1:0]      RdV;
    logic [HW-1:0]      RdH;
    logic [1:0]         RdCell;
    logic [SCORE_W-1:0] Score;
    logic [LW-1:0]      Length;
    logic [1:0]         State;
    logic               GameOver;

    modport master (
        output Tick, Start, Pause, DirValid, Dir, FoodValid, FoodV, FoodH, RdV, RdH,
        input  FoodReq, RdCell, Score, Length, State, GameOver
    );

    modport slave (
        input  Tick, Start, Pause, DirValid, Dir, FoodValid, FoodV, FoodH, RdV, RdH,
        output FoodReq, RdCell, Score, Length, State, GameOver
    );
endinterface

// File: rtl/snake_engine.sv
// Snake game-logic core: circular coordinate queue + occupancy bitmap, stepped by Tick.
// Optional feature: define SNAKE_WRAP_EN for wrap-around borders (no walls, only self-collision ends the game).
module snake_engine #(
    parameter int unsigned GRID_W  = 40,
    parameter int unsigned GRID_H  = 30,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned SCORE_W = 16
) (
    input  logic          Clock,
    input  logic          ResetN,
    snake_engine_if.slave bus
);
    localparam int unsigned HW    = $clog2(GRID_W);
    localparam int unsigned VW    = $clog2(GRID_H);
    localparam int unsigned LW    = $clog2(MAX_LEN + 1);
    localparam int unsigned PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned CIW   = $clog2(CELLS);
`ifdef SNAKE_WRAP_EN
    localparam bit WALLS_EN = 1'b0;
`else
    localparam bit WALLS_EN = 1'b1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SS_WAIT   = 2'd0,
        SS_CALC   = 2'd1,
        SS_CHECK  = 2'd2,
        SS_COMMIT = 2'd3
    } sub_e;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SNAKE = 2'b01;
    localparam logic [1:0] CELL_FOOD  = 2'b10;
    localparam logic [1:0] CELL_WALL  = 2'b11;

    function automatic logic in_range(input logic [VW-1:0] v, input logic [HW-1:0] h);
        return (32'(v) < GRID_H) && (32'(h) < GRID_W);
    endfunction

    function automatic logic is_wall(input logic [VW-1:0] v, input logic [HW-1:0] h);
        return WALLS_EN && ((v == '0) || (v == VW'(GRID_H - 1)) ||
                            (h == '0) || (h == HW'(GRID_W - 1)));
    endfunction

    function automatic logic [CIW-1:0] cell_idx(input logic [VW-1:0] v, input logic [HW-1:0] h);
        return CIW'(32'(v) * GRID_W + 32'(h));
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == MAX_LEN - 1) ? '0 : p + PW'(1);
    endfunction

    // FSM state
    state_e state_q, state_d;
    sub_e   sub_q, sub_d;
    logic   pause_pend_q, pause_pend_d;

    // Datapath state
    logic [1:0]         heading_q, heading_d;
    logic [1:0]         pend_dir_q, pend_dir_d;
    logic               pend_vld_q, pend_vld_d;
    logic [PW-1:0]      head_ptr_q, head_ptr_d;
    logic [PW-1:0]      tail_ptr_q, tail_ptr_d;
    logic [LW-1:0]      len_q, len_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [VW-1:0]      nxt_v_q, nxt_v_d;
    logic [HW-1:0]      nxt_h_q, nxt_h_d;
    logic               eat_q, eat_d;
    logic               food_vld_q, food_vld_d;
    logic [VW-1:0]      food_v_q, food_v_d;
    logic [HW-1:0]      food_h_q, food_h_d;
    logic               food_req_q, food_req_d;
    logic [CELLS-1:0]   bitmap_q, bitmap_d;
    logic [1:0]         rd_cell_q, rd_cell_d;
    logic               game_over_q, game_over_d;

    // Segment queue storage (no reset needed: only read after a game is initialised)
    logic [VW-1:0] q_v_mem [MAX_LEN];
    logic [HW-1:0] q_h_mem [MAX_LEN];
    logic          mem_we_c;
    logic [PW-1:0] mem_addr_c;
    logic [VW-1:0] mem_v_c;
    logic [HW-1:0] mem_h_c;

    logic [VW-1:0] head_v_c, tail_v_c, calc_v_c;
    logic [HW-1:0] head_h_c, tail_h_c, calc_h_c;
    logic          run_c, init_c, eat_c, collide_c, food_ok_c, pop_c;
    logic [PW-1:0] new_head_c;

    assign head_v_c = q_v_mem[head_ptr_q];
    assign head_h_c = q_h_mem[head_ptr_q];
    assign tail_v_c = q_v_mem[tail_ptr_q];
    assign tail_h_c = q_h_mem[tail_ptr_q];

    assign run_c  = (state_q == ST_RUN);
    assign init_c = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && bus.Start;

    // Moving into the tail is legal unless the snake grows this step.
    always_comb begin : check_logic
        eat_c     = food_vld_q && (nxt_v_q == food_v_q) && (nxt_h_q == food_h_q);
        collide_c = is_wall(nxt_v_q, nxt_h_q) ||
                    (bitmap_q[cell_idx(nxt_v_q, nxt_h_q)] &&
                     !(!eat_c && (nxt_v_q == tail_v_c) && (nxt_h_q == tail_h_c)));
    end

    // Candidate food must be a free, non-wall cell and not the head about to be committed.
    always_comb begin : food_check
        food_ok_c = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) &&
                    in_range(bus.FoodV, bus.FoodH) &&
                    !is_wall(bus.FoodV, bus.FoodH) &&
                    !bitmap_q[cell_idx(bus.FoodV, bus.FoodH)] &&
                    !(run_c && ((sub_q == SS_CHECK) || (sub_q == SS_COMMIT)) &&
                      (bus.FoodV == nxt_v_q) && (bus.FoodH == nxt_h_q));
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q      <= ST_IDLE;
            sub_q        <= SS_WAIT;
            pause_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sub_q        <= sub_d;
            pause_pend_q <= pause_pend_d;
        end
    end

    // FSM next state; Start beats Tick, and Pause requested mid-step waits for COMMIT.
    always_comb begin : fsm_next
        state_d      = state_q;
        sub_d        = sub_q;
        pause_pend_d = pause_pend_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.Start) begin
                    state_d      = ST_RUN;
                    sub_d        = SS_WAIT;
                    pause_pend_d = 1'b0;
                end
            end
            ST_RUN: begin
                unique case (sub_q)
                    SS_WAIT: begin
                        if (bus.Pause) begin
                            state_d = ST_PAUSE;
                        end else if (bus.Tick) begin
                            sub_d = SS_CALC;
                        end
                    end
                    SS_CALC: begin
                        sub_d = SS_CHECK;
                        if (bus.Pause) pause_pend_d = 1'b1;
                    end
                    SS_CHECK: begin
                        if (collide_c) begin
                            state_d      = ST_OVER;
                            sub_d        = SS_WAIT;
                            pause_pend_d = 1'b0;
                        end else begin
                            sub_d = SS_COMMIT;
                            if (bus.Pause) pause_pend_d = 1'b1;
                        end
                    end
                    SS_COMMIT: begin
                        sub_d        = SS_WAIT;
                        pause_pend_d = 1'b0;
                        if (pause_pend_q || bus.Pause) state_d = ST_PAUSE;
                    end
                endcase
            end
            ST_PAUSE: begin
                if (bus.Pause) state_d = ST_RUN;
            end
        endcase
    end

    // Datapath and registered outputs
    always_comb begin : datapath_next
        heading_d   = heading_q;
        pend_dir_d  = pend_dir_q;
        pend_vld_d  = pend_vld_q;
        head_ptr_d  = head_ptr_q;
        tail_ptr_d  = tail_ptr_q;
        len_d       = len_q;
        score_d     = score_q;
        nxt_v_d     = nxt_v_q;
        nxt_h_d     = nxt_h_q;
        eat_d       = eat_q;
        food_vld_d  = food_vld_q;
        food_v_d    = food_v_q;
        food_h_d    = food_h_q;
        food_req_d  = food_req_q;
        bitmap_d    = bitmap_q;
        rd_cell_d   = CELL_EMPTY;
        game_over_d = (state_d == ST_OVER);
        mem_we_c    = 1'b0;
        mem_addr_c  = head_ptr_q;
        mem_v_c     = nxt_v_q;
        mem_h_c     = nxt_h_q;
        calc_v_c    = head_v_c;
        calc_h_c    = head_h_c;
        new_head_c  = ptr_inc(head_ptr_q);
        pop_c       = !eat_q || (len_q == LW'(MAX_LEN));

        // Pending direction becomes the heading unless it reverses the snake.
        if (run_c && (sub_q == SS_CALC)) begin
            if (pend_vld_q && (pend_dir_q != (heading_q ^ 2'b01))) heading_d = pend_dir_q;
            pend_vld_d = 1'b0;
            unique case (heading_d)
                DIR_UP:    calc_v_c = (head_v_c == VW'(GRID_H - 1)) ? '0 : head_v_c + VW'(1);
                DIR_DOWN:  calc_v_c = (head_v_c == '0) ? VW'(GRID_H - 1) : head_v_c - VW'(1);
                DIR_LEFT:  calc_h_c = (head_h_c == '0) ? HW'(GRID_W - 1) : head_h_c - HW'(1);
                DIR_RIGHT: calc_h_c = (head_h_c == HW'(GRID_W - 1)) ? '0 : head_h_c + HW'(1);
            endcase
            nxt_v_d = calc_v_c;
            nxt_h_d = calc_h_c;
        end

        if (bus.DirValid) begin
            pend_dir_d = bus.Dir;
            pend_vld_d = 1'b1;
        end

        if (run_c && (sub_q == SS_CHECK)) eat_d = eat_c;

        // Tail is cleared before the head is set so a move into the tail leaves it occupied.
        if (run_c && (sub_q == SS_COMMIT)) begin
            mem_we_c   = 1'b1;
            mem_addr_c = new_head_c;
            head_ptr_d = new_head_c;
            if (pop_c) begin
                bitmap_d[cell_idx(tail_v_c, tail_h_c)] = 1'b0;
                tail_ptr_d = ptr_inc(tail_ptr_q);
            end
            bitmap_d[cell_idx(nxt_v_q, nxt_h_q)] = 1'b1;
            if (eat_q) begin
                if (len_q != LW'(MAX_LEN)) len_d = len_q + LW'(1);
                if (score_q != '1) score_d = score_q + SCORE_W'(1);
                food_vld_d = 1'b0;
                food_req_d = 1'b1;
            end
        end

        if (food_req_q && bus.FoodValid && food_ok_c) begin
            food_vld_d = 1'b1;
            food_v_d   = bus.FoodV;
            food_h_d   = bus.FoodH;
            food_req_d = 1'b0;
        end

        if (init_c) begin
            bitmap_d                          = '0;
            bitmap_d[cell_idx(VW'(1), HW'(1))] = 1'b1;
            head_ptr_d = '0;
            tail_ptr_d = '0;
            mem_we_c   = 1'b1;
            mem_addr_c = '0;
            mem_v_c    = VW'(1);
            mem_h_c    = HW'(1);
            len_d      = LW'(1);
            score_d    = '0;
            heading_d  = DIR_RIGHT;
            pend_vld_d = 1'b0;
            eat_d      = 1'b0;
            food_vld_d = 1'b0;
            food_req_d = 1'b1;
        end

        // Renderer read port; the board is blank until a game exists.
        if ((state_q != ST_IDLE) && in_range(bus.RdV, bus.RdH)) begin
            if (is_wall(bus.RdV, bus.RdH)) begin
                rd_cell_d = CELL_WALL;
            end else if (bitmap_q[cell_idx(bus.RdV, bus.RdH)]) begin
                rd_cell_d = CELL_SNAKE;
            end else if (food_vld_q && (bus.RdV == food_v_q) && (bus.RdH == food_h_q)) begin
                rd_cell_d = CELL_FOOD;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            heading_q   <= DIR_RIGHT;
            pend_dir_q  <= DIR_UP;
            pend_vld_q  <= 1'b0;
            head_ptr_q  <= '0;
            tail_ptr_q  <= '0;
            len_q       <= '0;
            score_q     <= '0;
            nxt_v_q     <= '0;
            nxt_h_q     <= '0;
            eat_q       <= 1'b0;
            food_vld_q  <= 1'b0;
            food_v_q    <= '0;
            food_h_q    <= '0;
            food_req_q  <= 1'b0;
            bitmap_q    <= '0;
            rd_cell_q   <= CELL_EMPTY;
            game_over_q <= 1'b0;
        end else begin
            heading_q   <= heading_d;
            pend_dir_q  <= pend_dir_d;
            pend_vld_q  <= pend_vld_d;
            head_ptr_q  <= head_ptr_d;
            tail_ptr_q  <= tail_ptr_d;
            len_q       <= len_d;
            score_q     <= score_d;
            nxt_v_q     <= nxt_v_d;
            nxt_h_q     <= nxt_h_d;
            eat_q       <= eat_d;
            food_vld_q  <= food_vld_d;
            food_v_q    <= food_v_d;
            food_h_q    <= food_h_d;
            food_req_q  <= food_req_d;
            bitmap_q    <= bitmap_d;
            rd_cell_q   <= rd_cell_d;
            game_over_q <= game_over_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (ResetN && mem_we_c) begin
            q_v_mem[mem_addr_c] <= mem_v_c;
            q_h_mem[mem_addr_c] <= mem_h_c;
        end
    end

    assign bus.FoodReq  = food_req_q;
    assign bus.RdCell   = rd_cell_q;
    assign bus.Score    = score_q;
    assign bus.Length   = len_q;
    assign bus.State    = state_q;
    assign bus.GameOver = game_over_q;
endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised Snake game-logic core, successor to the fixed-size game block. It holds the snake as a circular coordinate queue plus an occupancy bitmap, advances one step per `Tick`, and arbitrates food placement with the food randomiser through a request/valid handshake. It serves cell state to the VGA renderer through a registered read port and exposes score, length and game state for the seven-segment controller.

## Interface
- `GRID_W`, 40: grid columns, including the border wall columns; minimum 4.
- `GRID_H`, 30: grid rows, including the border wall rows; minimum 4.
- `MAX_LEN`, 64: snake queue depth, in segments; minimum 2.
- `SCORE_W`, 16: score counter width.
- Derived widths: `HW = $clog2(GRID_W)`, `VW = $clog2(GRID_H)`, `LW = $clog2(MAX_LEN+1)`.

Ports:
- `Clock` in 1: sole clock.
- `ResetN` in 1: reset is synchronous and active-low.
- `Tick` in 1: one-cycle step pulse from the game clock divider.
- `Start` in 1: pulse; starts a new game from IDLE or OVER.
- `Pause` in 1: pulse; toggles RUN/PAUSE.
- `DirValid` in 1, `Dir` in 2: direction request. Encoding: 00 up (V+1), 01 down (V−1), 10 left (H−1), 11 right (H+1).
- `FoodReq` out 1: engine needs a food position.
- `FoodValid` in 1, `FoodV` in VW, `FoodH` in HW: candidate food position from the randomiser.
- `RdV` in VW, `RdH` in HW: renderer cell query.
- `RdCell` out 2: registered cell state. Encoding: 00 empty, 01 snake, 10 food, 11 wall.
- `Score` out SCORE_W, `Length` out LW, `State` out 2, `GameOver` out 1.

## Operation
- States (`State` encoding):
  - IDLE = 0.
  - RUN = 1.
  - PAUSE = 2.
  - OVER = 3.
- Step sub-FSM inside RUN: WAIT → CALC → CHECK → COMMIT → WAIT.
- Transitions:
  - IDLE or OVER + `Start`: initialise the game, then go to RUN.
  - RUN + `Pause`: go to PAUSE. The pause is taken only from sub-state WAIT; if a step is in progress, the pause is deferred until COMMIT completes.
  - PAUSE + `Pause`: go to RUN.
  - Collision in CHECK: go to OVER.
- Initialisation:
  - Bitmap and queue cleared; snake length 1 at (V=1, H=1), heading right.
  - Score 0; food absent; `FoodReq` = 1.
- Direction handling:
  - Every `DirValid` latches `Dir` into a pending register; the last request before CALC wins.
  - A pending direction exactly opposite the current heading is discarded.
  - The pending direction becomes the heading at CALC.
- CALC: next head = head + heading.
- CHECK:
  - Eat = next head equals the food position and food is present.
  - Collision = next head on a border cell, or next head occupied in the bitmap. When not eating, the current tail cell counts as vacated, so moving into the tail is legal.
- COMMIT (no collision):
  - Push the next head onto the queue and set its bitmap bit.
  - If not eating: pop the tail and clear its bitmap bit.
  - If eating: length grows by 1, saturating at MAX_LEN. At MAX_LEN the tail pops anyway. Score increments, saturating at all-ones. Food becomes absent and `FoodReq` rises.
- Food handshake:
  - While `FoodReq` = 1, a `FoodValid` cycle is accepted only if the candidate is not a wall and not occupied in the bitmap.
  - Accepted: the food is placed and `FoodReq` falls on the next edge.
  - Rejected: ignored; `FoodReq` stays high.
  - `FoodValid` while `FoodReq` = 0 is ignored.
- `GameOver` = (`State` == OVER). In OVER the bitmap is frozen so the final board stays visible.

## Timing
- Reset: when `ResetN` is sampled low on a `Clock` edge, all state takes reset values on that edge:
  - `State` = IDLE, `Score` = 0, `Length` = 0, `FoodReq` = 0, `GameOver` = 0, `RdCell` = 00.
  - Bitmap and pending direction cleared; heading = right.
  - Reset has priority over every other input, including mid-step.
- Step latency: `Tick` sampled in RUN/WAIT at edge N produces updated head, tail, `Length` and `Score` after edge N+3. `GameOver` is high after edge N+2.
- A `Tick` arriving outside RUN/WAIT is dropped, not queued.
- If `Start` and `Tick` arrive in the same cycle, `Start` wins and the `Tick` is dropped.
- `RdCell` latency: exactly one cycle. It reflects board state as of the previous edge, and walls are decoded from coordinates.
- If a food acceptance and a COMMIT target the same cell in the same cycle, COMMIT wins, the food is rejected and `FoodReq` stays high.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - Border cells are not walls.
  - Head coordinates wrap modulo `GRID_W`/`GRID_H`; e.g. H = `GRID_W`−1 moving right gives H = 0.
  - `RdCell` never reports 11.
  - Only self-collision ends the game.
- `SNAKE_WRAP_EN` undefined: row/column 0 and the last row/column are walls, and entering one ends the game.

## Test plan
- Reset, then `Start`, then 3 `Tick`s with no direction input → head at (1,4), `Length` 1, `Score` 0, `State` 1.
- Heading right, `DirValid` with `Dir` = 10 (left), then `Tick` → reversal discarded, head H increments.
- Food accepted at (1,3), then 2 `Tick`s → `Score` 1, `Length` 2, `FoodReq` high at the cycle after the eating COMMIT. Candidate (1,2) on the snake → rejected, `FoodReq` stays high.
- Head at (1,`GRID_W`−2) heading right, then `Tick` → `GameOver` = 1 at N+2. With `SNAKE_WRAP_EN` defined, the same column-wrap stimulus (head at H = `GRID_W`−1) → head at (1,0) and the game continues.
- `Pause` pulse issued mid-step (at CHECK) → PAUSE is entered after COMMIT. `Tick` pulses while paused → no movement. A second `Pause` → RUN resumes.
- `ResetN` low during CALC → all outputs at their reset values the next cycle and `RdCell` = 00 everywhere.
